// File: rtl/blit_sequencer_pkg.sv
// Shared types for the blit command sequencer: blitter opcodes,
// sequencer state encoding and the queued command entry layout.
package blit_sequencer_pkg;

   localparam logic [2:0] BLIT_OP_CLEAR        = 3'd0;
   localparam logic [2:0] BLIT_OP_SCROLL_DOWN  = 3'd1;
   localparam logic [2:0] BLIT_OP_SCROLL_LEFT  = 3'd2;
   localparam logic [2:0] BLIT_OP_SCROLL_RIGHT = 3'd3;
   localparam logic [2:0] BLIT_OP_SPRITE       = 3'd4;
   localparam logic [2:0] BLIT_OP_SPRITE_16    = 3'd5;

   typedef enum logic [1:0] {
      SEQ_STATE_IDLE    = 2'd0,
      SEQ_STATE_ISSUE   = 2'd1,
      SEQ_STATE_RUN     = 2'd2,
      SEQ_STATE_RELEASE = 2'd3
   } seq_state_t;

   // Field order from MSB down fixes the bit offsets of a queued entry.
   typedef struct packed {
      logic        mode;
      logic        hires;
      logic [2:0]  op;
      logic [11:0] src;
      logic [3:0]  height;
      logic [6:0]  x;
      logic [5:0]  y;
   } seq_entry_t;

   localparam int ENTRY_W = $bits(seq_entry_t);

   // Only sprite draws produce a meaningful collision result for VF.
   function automatic logic isSpriteOp(input logic [2:0] op);
      return (op == BLIT_OP_SPRITE) || (op == BLIT_OP_SPRITE_16);
   endfunction

endpackage

// File: rtl/blit_sequencer_fifo.sv
// Small synchronous command FIFO: wrapping read/write pointers plus an
// occupancy counter one bit wider than the pointers.
module blit_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_data   = r_mem[r_rdPtr];
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Storage needs no reset; only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; a push and pop
   // in the same cycle leave the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/blit_sequencer.sv
// Queues blit and display-mode commands from the CPU and feeds them to the
// blitter one at a time over its enable/ready handshake.
module blit_sequencer
   import blit_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_mode,
   input  logic        cmd_hires,
   input  logic [2:0]  cmd_op,
   input  logic [11:0] cmd_src,
   input  logic [3:0]  cmd_height,
   input  logic [6:0]  cmd_x,
   input  logic [5:0]  cmd_y,
   output logic [2:0]  blit_operation,
   output logic [11:0] blit_src,
   output logic [3:0]  blit_height,
   output logic [6:0]  blit_x,
   output logic [5:0]  blit_y,
   output logic        blit_hires,
   output logic        blit_enable,
   input  logic        blit_ready,
   input  logic        blit_collision,
   output logic        done,
   output logic        collision,
   output logic        busy
);

   seq_state_t       r_state;
   logic [2:0]       r_op;
   logic [11:0]      r_src;
   logic [3:0]       r_height;
   logic [6:0]       r_x;
   logic [5:0]       r_y;
   logic             r_hires;
   logic             r_enable;
   logic             r_done;
   logic             r_collision;

   seq_entry_t       w_pushEntry;
   seq_entry_t       w_head;
   logic [ENTRY_W-1:0] w_headBits;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [PTR_W:0]   w_count;

   assign w_pushEntry = '{mode: cmd_mode, hires: cmd_hires, op: cmd_op, src: cmd_src,
                          height: cmd_height, x: cmd_x, y: cmd_y};
   assign w_head      = seq_entry_t'(w_headBits);
   assign cmd_ready   = !w_full;
   assign w_push      = cmd_valid && cmd_ready;
   // Mode entries drain unconditionally; blits only leave when the blitter is parked ready.
   assign w_pop       = (r_state == SEQ_STATE_IDLE) && !w_empty && (w_head.mode || blit_ready);

   blit_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pushEntry),
      .o_data  (w_headBits),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Handshake FSM; operands and display mode are only ever loaded in IDLE so
   // the blitter sees them stable for the whole operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= SEQ_STATE_IDLE;
         r_op        <= '0;
         r_src       <= '0;
         r_height    <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_hires     <= 1'b0;
         r_enable    <= 1'b0;
         r_done      <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            SEQ_STATE_IDLE: begin
               if (!w_empty) begin
                  if (w_head.mode) begin
                     r_hires <= w_head.hires;
                  end else if (blit_ready) begin
                     r_op     <= w_head.op;
                     r_src    <= w_head.src;
                     r_height <= w_head.height;
                     r_x      <= w_head.x;
                     r_y      <= w_head.y;
                     r_enable <= 1'b1;
                     r_state  <= SEQ_STATE_ISSUE;
                  end
               end
            end
            SEQ_STATE_ISSUE: begin
               if (!blit_ready) begin
                  r_state <= SEQ_STATE_RUN;
               end
            end
            SEQ_STATE_RUN: begin
               if (blit_ready) begin
                  r_enable <= 1'b0;
                  r_done   <= 1'b1;
                  if (isSpriteOp(r_op)) begin
                     r_collision <= blit_collision;
                  end
                  r_state <= SEQ_STATE_RELEASE;
               end
            end
            SEQ_STATE_RELEASE: begin
               // One cycle of enable low lets the blitter leave its done state.
               r_state <= SEQ_STATE_IDLE;
            end
            default: begin
               r_state <= SEQ_STATE_IDLE;
            end
         endcase
      end
   end

   assign blit_operation = r_op;
   assign blit_src       = r_src;
   assign blit_height    = r_height;
   assign blit_x         = r_x;
   assign blit_y         = r_y;
   assign blit_hires     = r_hires;
   assign blit_enable    = r_enable;
   assign done           = r_done;
   assign collision      = r_collision;
   assign busy           = (w_count != '0) || (r_state != SEQ_STATE_IDLE);

endmodule
